// File: rtl/fu_sharemod_merge_bus_if.sv
// rtl/fu_sharemod_merge_bus_if.sv - slice-in / word-out handshake bundle for the merge bus
// in_signed exists only when FU_SHAREMOD_MERGE_SIGNEXT_EN is defined.
interface fu_sharemod_merge_bus_if #(
  parameter int BUS_WIDTH      = 64,
  parameter int SPLITTER_WIDTH = 8
);
  localparam int SPLITTER_COUNT = BUS_WIDTH / SPLITTER_WIDTH;
  localparam int CW             = $clog2(SPLITTER_COUNT) + 1;

  logic [SPLITTER_WIDTH-1:0] in_slice;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
  logic                      in_signed;
`endif
  logic [BUS_WIDTH-1:0]      out_bus;
  logic [CW-1:0]             out_count;
  logic                      out_valid;
  logic                      out_ready;

`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
  modport master (output in_slice, in_valid, in_last, in_signed, out_ready,
                  input  in_ready, out_bus, out_count, out_valid);
  modport slave  (input  in_slice, in_valid, in_last, in_signed, out_ready,
                  output in_ready, out_bus, out_count, out_valid);
`else
  modport master (output in_slice, in_valid, in_last, out_ready,
                  input  in_ready, out_bus, out_count, out_valid);
  modport slave  (input  in_slice, in_valid, in_last, out_ready,
                  output in_ready, out_bus, out_count, out_valid);
`endif
endinterface

// File: rtl/fu_sharemod_merge_bus.sv
// rtl/fu_sharemod_merge_bus.sv - packs serial slices LSB-first into a registered bus word
// FU_SHAREMOD_MERGE_SIGNEXT_EN: pad short words with the last slice's MSB when in_signed=1.
module fu_sharemod_merge_bus #(
  parameter int BUS_WIDTH      = 64,
  parameter int SPLITTER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fu_sharemod_merge_bus_if.slave bus
);
  localparam int SW = SPLITTER_WIDTH;
  localparam int SC = BUS_WIDTH / SPLITTER_WIDTH;
  localparam int CW = $clog2(SC) + 1;

  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic [BUS_WIDTH-1:0] out_bus_q, out_bus_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;

  logic [BUS_WIDTH-1:0] merged;
  logic [BUS_WIDTH-1:0] acc_wr;
  logic [SW-1:0]        pad;
  logic                 last_pos;
  logic                 ready;
  logic                 accept;
  logic                 complete;

  assign last_pos = (cnt_q == CW'(SC - 1));
  // Only a word-completing slice needs the output register free.
  assign ready    = (!last_pos && !bus.in_last) || !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && ready;
  assign complete = accept && (last_pos || bus.in_last);

`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
  assign pad = (bus.in_signed && bus.in_slice[SW-1]) ? {SW{1'b1}} : {SW{1'b0}};
`else
  assign pad = {SW{1'b0}};
`endif

  always_comb begin
    merged = '0;
    acc_wr = acc_q;
    for (int j = 0; j < SC; j++) begin
      if (CW'(j) < cnt_q) begin
        merged[j*SW +: SW] = acc_q[j*SW +: SW];
      end else if (CW'(j) == cnt_q) begin
        merged[j*SW +: SW] = bus.in_slice;
        acc_wr[j*SW +: SW] = bus.in_slice;
      end else begin
        merged[j*SW +: SW] = pad;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_bus_d   = out_bus_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (complete) begin
      out_bus_d   = merged;
      out_count_d = cnt_q + CW'(1);
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (accept) begin
      acc_d = acc_wr;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_bus_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_bus_q   <= out_bus_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_bus   = out_bus_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fu_sharemod_merge_bus.sv
// tb/tb_fu_sharemod_merge_bus.sv - directed and randomized bench for fu_sharemod_merge_bus
module tb_fu_sharemod_merge_bus;
  localparam int BW = 64;
  localparam int SW = 8;
  localparam int SC = BW / SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_sharemod_merge_bus_if #(.BUS_WIDTH(BW), .SPLITTER_WIDTH(SW)) bus ();
  fu_sharemod_merge_bus #(.BUS_WIDTH(BW), .SPLITTER_WIDTH(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: slices collected into a word; finished words wait in a queue until taken.
  logic [63:0] exp_bus_q[$];
  int          exp_cnt_q[$];
  logic [63:0] cur_word;
  int          cur_n;
  int          n_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_bus_q.delete();
    exp_cnt_q.delete();
    cur_word = '0;
    cur_n    = 0;
  endtask

  task automatic cycle(output bit accepted);
    bit          exp_rdy;
    bit          pending;
    logic [7:0]  s;
    @(negedge clk);
    pending = (exp_bus_q.size() != 0);
    check("out_valid", 64'(bus.out_valid), 64'(pending));
    if (pending) begin
      check("out_bus", bus.out_bus, exp_bus_q[0]);
      check("out_count", 64'(bus.out_count), 64'(exp_cnt_q[0]));
    end
    exp_rdy = !(cur_n == SC - 1 || bus.in_last) || !pending || bus.out_ready;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (pending && bus.out_ready) begin
      void'(exp_bus_q.pop_front());
      void'(exp_cnt_q.pop_front());
      n_out++;
    end
    accepted = bus.in_valid && exp_rdy;
    if (accepted) begin
      s = bus.in_slice;
      cur_word = cur_word | (64'(s) << (SW * cur_n));
      cur_n++;
      if (cur_n == SC || bus.in_last) begin
`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
        if (bus.in_signed && s[7] && cur_n < SC)
          cur_word = cur_word | ~((64'd1 << (SW * cur_n)) - 64'd1);
`endif
        exp_bus_q.push_back(cur_word);
        exp_cnt_q.push_back(cur_n);
        cur_word = '0;
        cur_n    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] slice, input bit last);
    bit a;
    int budget;
    bus.in_slice = slice;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    a = 1'b0;
    budget = 0;
    while (!a && budget < 50) begin
      cycle(a);
      budget++;
    end
    if (!a) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) cycle(a);
  endtask

  task automatic reset_now(input string tag);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_bus"}, bus.out_bus, 64'd0);
    check({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a;
    int gaps;
    int n0;
    logic [63:0] word_a, word_b;
    bus.in_slice  = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
    bus.in_signed = 1'b0;
`endif
    model_clear();
    n_out = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_bus", bus.out_bus, 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word, back-to-back, visible one cycle after the last slice.
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_bus", bus.out_bus, 64'h0807060504030201);
    check("t1_count", 64'(bus.out_count), 64'd8);
    idle(1);

    // Early flush after three slices.
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    check("t2_bus", bus.out_bus, 64'h0000000000CCBBAA);
    check("t2_count", 64'(bus.out_count), 64'd3);
    idle(1);
    send(8'h5A, 1'b1);
    check("single_bus", bus.out_bus, 64'h5A);
    check("single_count", 64'(bus.out_count), 64'd1);
    idle(1);

`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
    bus.in_signed = 1'b1;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    check("t3_sext_bus", bus.out_bus, 64'hFFFFFFFFFFCCBBAA);
    idle(1);
    bus.in_signed = 1'b0;
`endif

    // Back-pressure: word A held while B streams; B's final slice waits.
    bus.out_ready = 1'b0;
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < 8; i++) begin
      send(8'hA0 + 8'(i), 1'b0);
      word_a = word_a | (64'(8'hA0 + 8'(i)) << (8 * i));
    end
    for (int i = 0; i < 8; i++) word_b = word_b | (64'(8'hB0 + 8'(i)) << (8 * i));
    for (int i = 0; i < 7; i++) send(8'hB0 + 8'(i), 1'b0);
    bus.in_slice = 8'hB7;
    bus.in_valid = 1'b1;
    repeat (2) begin
      cycle(a);
      check("t4_stall_ready", 64'(bus.in_ready), 64'd0);
      check("t4_hold_bus", bus.out_bus, word_a);
    end
    bus.out_ready = 1'b1;
    cycle(a);
    check("t4_accept", 64'(a), 64'd1);
    check("t4_b_valid", 64'(bus.out_valid), 64'd1);
    check("t4_b_bus", bus.out_bus, word_b);
    idle(1);

    // Four full words with random input gaps.
    n0 = n_out;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) begin
        gaps = $urandom_range(0, 2);
        if (gaps != 0) idle(gaps);
        send(8'($urandom), 1'b0);
      end
    end
    idle(3);
    check("t5_out_count", 64'(n_out - n0), 64'd4);

    // Random slices, early flushes and back-pressure.
    for (int k = 0; k < 300; k++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 4) != 0);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.in_slice  = 8'($urandom);
`ifdef FU_SHAREMOD_MERGE_SIGNEXT_EN
      bus.in_signed = 1'($urandom);
`endif
      cycle(a);
    end
    bus.out_ready = 1'b1;
    idle(3);
    check("rand_drained", 64'(exp_bus_q.size()), 64'd0);

    // Reset mid-word, then with a held word plus partial accumulator.
    for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), 1'b0);
    reset_now("t6a");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i), 1'b0);
    reset_now("t6b");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h11 * 8'(i + 1), 1'b0);
    check("t6_bus", bus.out_bus, 64'h8877665544332211);
    check("t6_count", 64'(bus.out_count), 64'd8);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
